ptw_mem_responder: RTL and testbench

// - Serves the page-table walker's memory-request interface (req/paddr/ready/full/data_valid/rdata).
// - Queues PTW line reads and issues each one as a burst read on a beat-based memory port.
// - Reassembles the beats into a DCACHE_BANK-word line and returns it with a 1-cycle data_valid.
// - Sits between the PTW and the L2/dcache read port.

---
 rtl/ptw_mem_responder_pkg.sv | 38 +++
 rtl/ptw_mem_responder_if.sv | 40 ++++
 rtl/ptw_mem_responder_req_fifo.sv | 67 ++++++
 rtl/ptw_mem_responder.sv | 139 +++++++++++++
 tb/tb_ptw_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ptw_mem_responder_pkg.sv
// ptw_mem_responder_pkg
// Shared definitions for the PTW memory responder slice.
// Contents:
//   - Geometry constants: address width, line shape, beat shape, queue depth.
//   - ptw_line_t: one returned line, BANK words of BITS bits, word i = bank i.
//   - ptw_state_e: responder FSM states.
//   - line_align(): clears the byte-offset bits of an address so that it
//     points at the start of its line.
package ptw_mem_responder_pkg;

    localparam int PADDR_W = 34;
    localparam int BANK    = 8;
    localparam int BITS    = 32;
    localparam int BEAT_W  = 64;
    localparam int QDEPTH  = 2;

    localparam int LINE_W  = BANK * BITS;
    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int OFF_W   = $clog2(LINE_W / 8);
    // The beat counter keeps at least one bit so that single-beat lines
    // still get a legal vector.
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_QW  = $clog2(QDEPTH + 1);

    typedef logic [BANK-1:0][BITS-1:0] ptw_line_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RECV,
        RESP
    } ptw_state_e;

    function automatic logic [PADDR_W-1:0] line_align(input logic [PADDR_W-1:0] addr);
        return {addr[PADDR_W-1:OFF_W], OFF_W'(0)};
    endfunction

endpackage

// File: rtl/ptw_mem_responder_if.sv
// Bus bundles for ptw_mem_responder.
// ptw_mem_responder_if: page-table-walker request side.
//   req, paddr   PTW -> responder   read request held until ready
//   ready, full  responder -> PTW   accept strobe and queue-full flag
//   data_valid   responder -> PTW   one-cycle line-return pulse
//   rdata        responder -> PTW   returned line
//   modport master = PTW, modport slave = responder
// ptw_mem_port_if: beat-based memory read port.
//   req_valid, req_addr     responder -> memory   burst read request
//   req_ready               memory -> responder   request accepted
//   resp_valid, resp_data,
//   resp_last               memory -> responder   response beats
//   modport master = responder, modport slave = memory
interface ptw_mem_responder_if;
    import ptw_mem_responder_pkg::*;

    logic               req;
    logic [PADDR_W-1:0] paddr;
    logic               ready;
    logic               full;
    logic               data_valid;
    ptw_line_t          rdata;

    modport master (output req, paddr, input ready, full, data_valid, rdata);
    modport slave  (input req, paddr, output ready, full, data_valid, rdata);
endinterface

interface ptw_mem_port_if;
    import ptw_mem_responder_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [PADDR_W-1:0] req_addr;
    logic               resp_valid;
    logic [BEAT_W-1:0]  resp_data;
    logic               resp_last;

    modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data, resp_last);
    modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data, resp_last);
endinterface

// File: rtl/ptw_mem_responder_req_fifo.sv
// ptw_req_fifo
// Small FIFO holding line addresses of accepted PTW reads until they are
// issued and answered.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   push, din    write din at the tail
//   pop          drop the head entry
//   dout         head entry
//   count        number of stored entries
//   full, empty  count == DEPTH / count == 0
// DEPTH must be a power of two so that the pointers wrap naturally.
module ptw_req_fifo
    import ptw_mem_responder_pkg::*;
#(
    parameter int DEPTH = QDEPTH,
    parameter int WIDTH = PADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CW-1:0]    count_q;

    // Storage, pointers and occupancy. A simultaneous push and pop moves
    // both pointers and leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                slot_q[tail_q] <= din;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = slot_q[head_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder
// Answers page-table-walker line reads. Accepted requests are queued,
// issued one at a time as burst reads on the memory port, and the response
// beats are reassembled into a full line returned with a one-cycle
// data_valid, strictly in request order.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   ptw        PTW request side (slave): req/paddr in, ready/full/data_valid/rdata out
//   mem        memory read port (master): burst request out, beats in
//   proto_err  sticky flag: resp_last arrived on a beat that was not the last
module ptw_mem_responder
    import ptw_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ptw_mem_responder_if.slave    ptw,
    ptw_mem_port_if.master        mem,
    output logic                  proto_err
);
    ptw_state_e         state_q;
    ptw_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [LINE_W-1:0]  line_q;
    logic [LINE_W-1:0]  line_next;
    ptw_line_t          rdata_q;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_QW-1:0]  fifo_count;
    logic [PADDR_W-1:0] head_addr;
    logic               beat_fire;
    logic               last_beat;

    // ready is held low while reset is asserted so that a PTW already
    // raising req sees no accept until the queue is live again.
    assign push      = ptw.req & ~fifo_full & ~rst;
    assign pop       = (state_q == RESP);
    assign beat_fire = (state_q == RECV) & mem.resp_valid;
    assign last_beat = beat_fire & (cnt_q == CNT_W'(BEATS - 1));

    assign ptw.ready      = push;
    assign ptw.full       = fifo_full;
    assign ptw.data_valid = pop;
    assign ptw.rdata      = rdata_q;
    assign mem.req_addr   = head_addr;

    ptw_req_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (PADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (line_align(ptw.paddr)),
        .pop   (pop),
        .dout  (head_addr),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Line register contents after the current beat is merged in. Computed
    // combinationally so the final beat can be forwarded straight into the
    // returned-line register on the same edge.
    always_comb begin
        line_next = line_q;
        line_next[32'(cnt_q) * BEAT_W +: BEAT_W] = mem.resp_data;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory request strobe. A push in the current cycle is
    // enough to leave IDLE, which gives the accept-to-issue latency of one
    // cycle. From RESP the queue is re-examined as it will be after the pop,
    // including any request accepted in that same cycle.
    always_comb begin
        state_d       = state_q;
        mem.req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty || push) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem.req_valid = 1'b1;
                if (mem.req_ready) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (last_beat) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if ((fifo_count > CNT_QW'(1)) || push) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat collection. Completion is decided purely by the beat count;
    // resp_last is only used to flag a memory that ends a burst early.
    // The returned line is refreshed only when a burst completes, so the
    // PTW sees a stable rdata while the next burst is being collected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            line_q    <= '0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (beat_fire) begin
                line_q <= line_next;
                cnt_q  <= last_beat ? '0 : cnt_q + CNT_W'(1);
                if (mem.resp_last && !last_beat) begin
                    proto_err <= 1'b1;
                end
            end
            if (last_beat) begin
                rdata_q <= ptw_line_t'(line_next);
            end
        end
    end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// tb_ptw_mem_responder
// Directed and randomized checks of ptw_mem_responder. A small memory model
// answers burst requests with chosen or random beats; the expected line is
// built by concatenating those beats, and the expected addresses come from
// rounding each PTW address down to a line boundary.
module tb_ptw_mem_responder;
    import ptw_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic proto_err;

    always #5 clk = ~clk;

    ptw_mem_responder_if ptw ();
    ptw_mem_port_if      mem ();

    ptw_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .ptw       (ptw),
        .mem       (mem),
        .proto_err (proto_err)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cycle_no     = 0;
    int dv_count     = 0;
    int dv_cycles[$];
    logic [LINE_W-1:0]  exp_lines[$];
    logic [PADDR_W-1:0] exp_addrs[$];
    logic [PADDR_W-1:0] last_mem_addr;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic reportMissing(input string tag);
        n_compared++;
        n_mismatched++;
        $error("[TB] FAIL %s: observed=no event expected=event", tag);
    endtask

    function automatic logic [PADDR_W-1:0] model_align(input logic [PADDR_W-1:0] a);
        return (a / (LINE_W / 8)) * (LINE_W / 8);
    endfunction

    // Every returned line must match the oldest outstanding expected line.
    always @(negedge clk) begin
        if (!rst && ptw.data_valid === 1'b1) begin
            dv_count++;
            dv_cycles.push_back(cycle_no);
            if (exp_lines.size() == 0) begin
                reportMissing("dv_unexpected");
            end else begin
                checkOutput("rdata", ptw.rdata, exp_lines.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendRequest(input logic [PADDR_W-1:0] addr, output int accept_cycle);
        bit done = 0;
        accept_cycle = -1;
        ptw.req   = 1'b1;
        ptw.paddr = addr;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ptw.ready === 1'b1) begin
                accept_cycle = cycle_no;
                exp_addrs.push_back(model_align(addr));
                done = 1;
            end
            tick();
        end
        ptw.req = 1'b0;
        if (!done) reportMissing("req_accept");
    endtask

    task automatic serveMem(input int ready_delay, input int gap, input int last_on,
                            input bit fixed_data, output int issue_cycle,
                            output int last_beat_cycle);
        logic [PADDR_W-1:0] want;
        logic [LINE_W-1:0]  line;
        logic [BEAT_W-1:0]  beat;
        bit seen = 0;
        issue_cycle     = -1;
        last_beat_cycle = -1;
        line            = '0;
        mem.req_ready   = (ready_delay == 0);
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (mem.req_valid === 1'b1) seen = 1;
            else tick();
        end
        if (!seen) begin
            reportMissing("mem_req_valid");
            mem.req_ready = 1'b0;
            return;
        end
        issue_cycle   = cycle_no;
        want          = (exp_addrs.size() > 0) ? exp_addrs.pop_front() : 'x;
        last_mem_addr = mem.req_addr;
        checkOutput("mem_req_addr", LINE_W'(mem.req_addr), LINE_W'(want));
        for (int i = 0; i < ready_delay; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("valid_hold", LINE_W'(mem.req_valid), LINE_W'(1'b1));
            checkOutput("addr_hold", LINE_W'(mem.req_addr), LINE_W'(want));
            tick();
        end
        if (ready_delay > 0) begin
            mem.req_ready = 1'b1;
            @(negedge clk);
            checkOutput("valid_at_ready", LINE_W'(mem.req_valid), LINE_W'(1'b1));
        end
        tick();
        mem.req_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            beat = fixed_data ? 64'h0101_0101_0101_0101 * (b + 1) : {$urandom, $urandom};
            line[b*BEAT_W +: BEAT_W] = beat;
            mem.resp_valid = 1'b1;
            mem.resp_data  = beat;
            mem.resp_last  = (b == last_on);
            if (b == BEATS - 1) begin
                last_beat_cycle = cycle_no;
                exp_lines.push_back(line);
            end
            tick();
            mem.resp_valid = 1'b0;
            mem.resp_last  = 1'b0;
            if (b < BEATS - 1) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
    endtask

    task automatic applyStimulus(input logic [PADDR_W-1:0] addr, input int ready_delay,
                                 input int gap, input int last_on, input bit fixed_data,
                                 output int accept_cycle, output int issue_cycle,
                                 output int last_beat_cycle);
        fork
            sendRequest(addr, accept_cycle);
            serveMem(ready_delay, gap, last_on, fixed_data, issue_cycle, last_beat_cycle);
        join
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, iss, lb, t1, t2, t3, dv0, i1, i2, i3, l1, l2, l3;
        bit seen;

        rst            = 1'b1;
        ptw.req        = 1'b1;
        ptw.paddr      = '0;
        mem.req_ready  = 1'b0;
        mem.resp_valid = 1'b0;
        mem.resp_data  = '0;
        mem.resp_last  = 1'b0;
        repeat (3) tick();

        // Reset values, with req already raised by the PTW.
        checkOutput("rst_ready", LINE_W'(ptw.ready), '0);
        checkOutput("rst_full", LINE_W'(ptw.full), '0);
        checkOutput("rst_dv", LINE_W'(ptw.data_valid), '0);
        checkOutput("rst_rdata", ptw.rdata, '0);
        checkOutput("rst_mem_req_valid", LINE_W'(mem.req_valid), '0);
        checkOutput("rst_proto_err", LINE_W'(proto_err), '0);
        ptw.req = 1'b0;
        rst     = 1'b0;
        tick();

        // Single request with known beats and ideal memory timing.
        applyStimulus(34'h0_8000_1234, 0, 0, BEATS - 1, 1'b1, t, iss, lb);
        repeat (3) tick();
        checkOutput("single_addr", LINE_W'(last_mem_addr), LINE_W'(34'h0_8000_1220));
        checkOutput("single_issue_lat", LINE_W'(iss), LINE_W'(t + 1));
        checkOutput("single_dv_lat", LINE_W'(dv_cycles[$]), LINE_W'(t + 2 + BEATS));
        checkOutput("single_word0", LINE_W'(ptw.rdata[0]), LINE_W'(32'h0101_0101));
        checkOutput("single_word7", LINE_W'(ptw.rdata[7]), LINE_W'(32'h0404_0404));
        checkOutput("single_pulse", LINE_W'(ptw.data_valid), '0);

        // Two back-to-back requests fill the queue; the third waits for the first pop.
        dv_cycles.delete();
        dv0 = dv_count;
        fork
            begin
                sendRequest(34'h1_2345_6788, t1);
                sendRequest(34'h0_0000_0040, t2);
                checkOutput("full_after_two", LINE_W'(ptw.full), LINE_W'(1'b1));
                sendRequest(34'h3_FFFF_FFFF, t3);
            end
            begin
                serveMem(0, 0, BEATS - 1, 1'b0, i1, l1);
                serveMem(0, 0, BEATS - 1, 1'b0, i2, l2);
                serveMem(0, 0, BEATS - 1, 1'b0, i3, l3);
            end
        join
        repeat (3) tick();
        checkOutput("b2b_second_accept", LINE_W'(t2), LINE_W'(t1 + 1));
        checkOutput("b2b_third_accept", LINE_W'(t3), LINE_W'(dv_cycles[0] + 1));
        checkOutput("b2b_dv_count", LINE_W'(dv_count - dv0), LINE_W'(3));

        // Memory withholds req_ready for five cycles.
        applyStimulus(PADDR_W'({$urandom, $urandom}), 5, 0, BEATS - 1, 1'b0, t, iss, lb);
        repeat (2) tick();
        checkOutput("stall_issue_lat", LINE_W'(iss), LINE_W'(t + 1));
        checkOutput("stall_dv_lat", LINE_W'(dv_cycles[$]), LINE_W'(t + 2 + BEATS + 5));

        // Beats arrive every third cycle.
        applyStimulus(PADDR_W'({$urandom, $urandom}), 0, 2, BEATS - 1, 1'b0, t, iss, lb);
        repeat (2) tick();
        checkOutput("gap_dv_lat", LINE_W'(dv_cycles[$]), LINE_W'(lb + 1));

        // Early resp_last on beat 1: flagged, sticky, and the line still completes.
        checkOutput("proto_before", LINE_W'(proto_err), '0);
        applyStimulus(PADDR_W'({$urandom, $urandom}), 0, 0, 1, 1'b0, t, iss, lb);
        repeat (2) tick();
        checkOutput("proto_set", LINE_W'(proto_err), LINE_W'(1'b1));
        checkOutput("proto_dv_lat", LINE_W'(dv_cycles[$]), LINE_W'(t + 2 + BEATS));
        applyStimulus(PADDR_W'({$urandom, $urandom}), 0, 0, BEATS - 1, 1'b0, t, iss, lb);
        repeat (2) tick();
        checkOutput("proto_sticky", LINE_W'(proto_err), LINE_W'(1'b1));

        // Reset in the middle of a burst.
        mem.req_ready = 1'b1;
        seen = 0;
        fork
            sendRequest(34'h2_0000_0F00, t);
            begin
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (mem.req_valid === 1'b1) seen = 1;
                    else tick();
                end
                if (!seen) reportMissing("rst_test_issue");
                checkOutput("rst_test_addr", LINE_W'(mem.req_addr),
                            LINE_W'(model_align(34'h2_0000_0F00)));
                tick();
                mem.req_ready = 1'b0;
                for (int b = 0; b < 2; b++) begin
                    mem.resp_valid = 1'b1;
                    mem.resp_data  = {$urandom, $urandom};
                    tick();
                end
                mem.resp_valid = 1'b0;
            end
        join
        ptw.req = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", LINE_W'(ptw.ready), '0);
        checkOutput("midrst_full", LINE_W'(ptw.full), '0);
        checkOutput("midrst_dv", LINE_W'(ptw.data_valid), '0);
        checkOutput("midrst_rdata", ptw.rdata, '0);
        checkOutput("midrst_mem_req_valid", LINE_W'(mem.req_valid), '0);
        checkOutput("midrst_proto_err", LINE_W'(proto_err), '0);
        tick();
        ptw.req = 1'b0;
        exp_lines.delete();
        exp_addrs.delete();
        rst = 1'b0;
        tick();
        dv0 = dv_count;
        applyStimulus(PADDR_W'({$urandom, $urandom}), 0, 0, BEATS - 1, 1'b0, t, iss, lb);
        repeat (2) tick();
        checkOutput("after_rst_dv_lat", LINE_W'(dv_cycles[$]), LINE_W'(t + 2 + BEATS));
        checkOutput("after_rst_dv_count", LINE_W'(dv_count - dv0), LINE_W'(1));

        // Randomized traffic: random addresses, request spacing, stalls and beat gaps.
        dv0 = dv_count;
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    sendRequest(PADDR_W'({$urandom, $urandom}), t1);
                end
            end
            begin
                for (int n = 0; n < 24; n++) begin
                    serveMem($urandom_range(0, 3), $urandom_range(0, 2), BEATS - 1, 1'b0, i1, l1);
                end
            end
        join
        for (int i = 0; i < 50 && dv_count != dv0 + 24; i++) tick();
        checkOutput("rand_dv_count", LINE_W'(dv_count - dv0), LINE_W'(24));
        checkOutput("rand_lines_left", LINE_W'(exp_lines.size()), '0);
        checkOutput("rand_addrs_left", LINE_W'(exp_addrs.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
